// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^M) polynomial-basis multiplier: C = A*B mod F(x), MSB-first, D bits of B per cycle.
// Latency ceil(M/D) cycles after the request edge; requests arriving while busy are dropped with an ERROR pulse.
module gf2m_digit_mul #(
  parameter int            M    = 163,
  parameter int            D    = 1,
  parameter logic [M-1:0]  POLY = 'hC9
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] C,
  output logic         OUT_VALID,
  output logic         BUSY,
  output logic         ERROR
);

  localparam int K  = (M + D - 1) / D;
  localparam int KD = K * D;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  // One-hot encoding leaves two illegal codes that the default arm recovers from.
  typedef enum logic [1:0] {
    S_IDLE = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  state_t          r_state;
  logic [M-1:0]    r_a;
  logic [KD-1:0]   r_b;
  logic [M-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic [M-1:0]    w_acc_next;
  logic [KD-1:0]   w_b_pad;

  // B is zero-padded at the top so the leading digits only shift an all-zero accumulator.
  assign w_b_pad = KD'(B);

  always_comb begin
    w_acc_next = r_acc;
    for (int j = 0; j < D; j++) begin
      w_acc_next = {w_acc_next[M-2:0], 1'b0}
                 ^ (w_acc_next[M-1]  ? POLY : '0)
                 ^ (r_b[KD-1-j]      ? r_a  : '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      C         <= '0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      ERROR     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (IN_VALID) begin
            r_a     <= A;
            r_b     <= w_b_pad;
            r_acc   <= '0;
            r_cnt   <= '0;
            BUSY    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (IN_VALID) begin
            ERROR <= 1'b1;
          end
          r_acc <= w_acc_next;
          r_b   <= r_b << D;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            C         <= w_acc_next;
            OUT_VALID <= 1'b1;
            BUSY      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          OUT_VALID <= 1'b0;
          BUSY      <= 1'b0;
          ERROR     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// Bench for gf2m_digit_mul: four instances (M=8 with D=1/4/3, M=163 with D=1) checked every cycle against a
// transaction-level model built on schoolbook carry-less multiplication followed by long-division reduction.
module tb_gf2m_digit_mul;

  localparam int          M_W[4]  = '{8, 8, 8, 163};
  localparam int          K_N[4]  = '{8, 2, 3, 163};
  localparam logic [162:0] PLY[4] = '{163'h1B, 163'h1B, 163'h1B, 163'hC9};

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv[4];
  logic [162:0] a_in[4];
  logic [162:0] b_in[4];
  logic [7:0]   c_d1, c_d4, c_d3;
  logic [162:0] c_big;
  logic [162:0] c_o[4];
  logic         ov_o[4];
  logic         busy_o[4];
  logic         err_o[4];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  gf2m_digit_mul #(.M(8), .D(1), .POLY(8'h1B)) u_d1 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[0]), .A(a_in[0][7:0]), .B(b_in[0][7:0]),
    .C(c_d1), .OUT_VALID(ov_o[0]), .BUSY(busy_o[0]), .ERROR(err_o[0]));
  gf2m_digit_mul #(.M(8), .D(4), .POLY(8'h1B)) u_d4 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[1]), .A(a_in[1][7:0]), .B(b_in[1][7:0]),
    .C(c_d4), .OUT_VALID(ov_o[1]), .BUSY(busy_o[1]), .ERROR(err_o[1]));
  gf2m_digit_mul #(.M(8), .D(3), .POLY(8'h1B)) u_d3 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[2]), .A(a_in[2][7:0]), .B(b_in[2][7:0]),
    .C(c_d3), .OUT_VALID(ov_o[2]), .BUSY(busy_o[2]), .ERROR(err_o[2]));
  gf2m_digit_mul u_big (
    .CLK(clk), .RST(rst), .IN_VALID(iv[3]), .A(a_in[3]), .B(b_in[3]),
    .C(c_big), .OUT_VALID(ov_o[3]), .BUSY(busy_o[3]), .ERROR(err_o[3]));

  always_comb begin
    c_o[0] = {155'b0, c_d1};
    c_o[1] = {155'b0, c_d4};
    c_o[2] = {155'b0, c_d3};
    c_o[3] = c_big;
  end

  // Full double-width carry-less product, then reduce from the top bit down by shifted copies of F(x).
  function automatic logic [162:0] gfmul(input logic [162:0] a, input logic [162:0] b,
                                         input int m, input logic [162:0] p);
    logic [325:0] pr;
    logic [325:0] f;
    pr = '0;
    f  = {163'b0, p} | (326'b1 << m);
    for (int i = 0; i < m; i++)
      if (b[i]) pr = pr ^ ({163'b0, a} << i);
    for (int i = 2 * m - 2; i >= m; i--)
      if (pr[i]) pr = pr ^ (f << (i - m));
    return pr[162:0];
  endfunction

  task automatic chk(input string nm, input logic [162:0] act, input logic [162:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: each accepted request becomes an outstanding product due K edges later.
  logic         mbusy[4], mov[4], merr[4];
  int           mcnt[4];
  logic [162:0] mc[4], mprod[4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mbusy[i] = 1'b0; mcnt[i] = 0; mc[i] = '0; mprod[i] = '0; mov[i] = 1'b0; merr[i] = 1'b0;
      end else begin
        mov[i]  = 1'b0;
        merr[i] = 1'b0;
        if (mbusy[i]) begin
          if (iv[i]) merr[i] = 1'b1;
          mcnt[i] = mcnt[i] - 1;
          if (mcnt[i] == 0) begin
            mc[i] = mprod[i]; mov[i] = 1'b1; mbusy[i] = 1'b0;
          end
        end else if (iv[i]) begin
          mbusy[i] = 1'b1;
          mcnt[i]  = K_N[i];
          mprod[i] = gfmul(a_in[i], b_in[i], M_W[i], PLY[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ov[%0d]", i),   {162'b0, ov_o[i]},   {162'b0, mov[i]});
        chk($sformatf("err[%0d]", i),  {162'b0, err_o[i]},  {162'b0, merr[i]});
        chk($sformatf("busy[%0d]", i), {162'b0, busy_o[i]}, {162'b0, mbusy[i]});
        chk($sformatf("c[%0d]", i),    c_o[i],              mc[i]);
      end
    end
  end

  task automatic wait_ov(input int i, output int n);
    n = 0;
    while (!ov_o[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ov_seen[%0d]", i), {162'b0, ov_o[i]}, 163'd1);
  endtask

  task automatic run_op(input int i, input logic [162:0] a, input logic [162:0] b,
                        input logic [162:0] exp, input int lat, input string nm);
    int n;
    @(negedge clk);
    a_in[i] = a; b_in[i] = b; iv[i] = 1'b1;
    @(negedge clk);
    iv[i] = 1'b0;
    wait_ov(i, n);
    chk({nm, "_lat"}, 163'(n), 163'(lat));
    chk({nm, "_c"}, c_o[i], exp);
  endtask

  initial begin
    int n;
    logic [162:0] rnd, rnd2, x162;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; a_in[i] = '0; b_in[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    x162 = 163'b1 << 162;
    chk("model_57x83", gfmul(163'h57, 163'h83, 8, 163'h1B), 163'hC1);
    chk("model_02x80", gfmul(163'h02, 163'h80, 8, 163'h1B), 163'h1B);
    chk("model_x163",  gfmul(x162, 163'h2, 163, 163'hC9),   163'hC9);
    chk("rst_c",    c_o[0], 163'h0);
    chk("rst_busy", {162'b0, busy_o[0]}, 163'h0);

    run_op(0, 163'h57, 163'h83, 163'hC1, 8, "d1");
    run_op(1, 163'h57, 163'h83, 163'hC1, 2, "d4");
    run_op(2, 163'h57, 163'h83, 163'hC1, 3, "d3");

    for (int k = 0; k < 163; k++) begin
      rnd[k]  = 1'($urandom_range(0, 1));
      rnd2[k] = 1'($urandom_range(0, 1));
    end
    run_op(3, rnd, 163'h1, rnd, 163, "big_b1");
    run_op(3, 163'h0, rnd2, 163'h0, 163, "big_a0");
    run_op(3, x162, 163'h2, 163'hC9, 163, "big_x163");

    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        a_in[i] = 163'($urandom_range(0, 255));
        b_in[i] = 163'($urandom_range(0, 255));
        iv[i]   = 1'b1;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) iv[i] = 1'b0;
      repeat (9) @(negedge clk);
    end

    // Back-to-back request in the OUT_VALID cycle, then a rejected request mid-operation.
    run_op(0, 163'h57, 163'h83, 163'hC1, 8, "b2b_first");
    a_in[0] = 163'h02; b_in[0] = 163'h80; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("b2b_ov_fall", {162'b0, ov_o[0]},   163'h0);
    chk("b2b_busy",    {162'b0, busy_o[0]}, 163'h1);
    repeat (2) @(negedge clk);
    a_in[0] = 163'hFF; b_in[0] = 163'hFF; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("err_pulse", {162'b0, err_o[0]}, 163'h1);
    wait_ov(0, n);
    chk("b2b_lat", 163'(n + 3), 163'd8);
    chk("b2b_c",   c_o[0],      163'h1B);

    // Reset at the third digit edge aborts the operation and clears C.
    @(negedge clk);
    a_in[0] = 163'h57; b_in[0] = 163'h83; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_c",    c_o[0],              163'h0);
    chk("midrst_busy", {162'b0, busy_o[0]}, 163'h0);
    for (int t = 0; t < 10; t++) begin
      chk("midrst_no_ov", {162'b0, ov_o[0]}, 163'h0);
      @(negedge clk);
    end
    run_op(0, 163'h57, 163'h83, 163'hC1, 8, "after_rst");

    // Operands change right after the sampling edge.
    @(negedge clk);
    a_in[0] = 163'h57; b_in[0] = 163'h83; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0; a_in[0] = 163'hFF; b_in[0] = 163'hFF;
    wait_ov(0, n);
    chk("hold_lat", 163'(n), 163'd8);
    chk("hold_c",   c_o[0],  163'hC1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
